// File: rtl/fetch_queue.sv
// Instruction fetch unit: single-outstanding req/ack memory port feeding a small
// prefetch FIFO of {pc, instr}, with redirect handling that abandons in-flight data.
package sp_pkg;
   parameter int ADDR_WIDTH = 32;
   parameter int DATA_WIDTH = 32;
endpackage

// state   | meaning
// --------+---------------------------------------------------------------
// S_FETCH | normal fetch; req while started and FIFO not full
// S_FLUSH | holding an abandoned request until its ack, then jump to tgt_q
module fetch_queue #(
   parameter int             AW          = sp_pkg::ADDR_WIDTH,
   parameter int             DW          = sp_pkg::DATA_WIDTH,
   parameter int             INSTR_BYTES = 2,
   parameter int             DEPTH       = 4,
   parameter logic [AW-1:0]  RESET_PC    = '0
) (
   input  logic          clk_i,
   input  logic          arst_ni,
   input  logic          redirect_i,
   input  logic [AW-1:0] redirect_pc_i,
   output logic          imem_req_o,
   output logic [AW-1:0] imem_addr_o,
   input  logic          imem_ack_i,
   input  logic [DW-1:0] imem_rdata_i,
   output logic          instr_valid_o,
   input  logic          instr_ready_i,
   output logic [DW-1:0] instr_o,
   output logic [AW-1:0] instr_pc_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {S_FETCH, S_FLUSH} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] fetch_pc_q;
   logic [AW-1:0] tgt_q;
   logic          en_q;
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] cnt_q;
   logic [AW-1:0] mem_pc    [DEPTH];
   logic [DW-1:0] mem_instr [DEPTH];

   logic xfer;
   logic push;
   logic pop;
   logic empty;

   assign xfer  = imem_req_o && imem_ack_i;
   assign push  = xfer && (state_q == S_FETCH) && !redirect_i;
   assign pop   = instr_valid_o && instr_ready_i;
   assign empty = (cnt_q == '0);

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH: if (redirect_i && imem_req_o && !imem_ack_i) state_d = S_FLUSH;
         S_FLUSH: if (imem_ack_i) state_d = S_FETCH;
         default: state_d = S_FETCH;
      endcase
   end

   // Request depends only on registered state so it cannot combinationally follow ack.
   always_comb begin
      imem_req_o  = 1'b0;
      imem_addr_o = fetch_pc_q;
      case (state_q)
         S_FETCH: imem_req_o = en_q && (cnt_q < CW'(DEPTH));
         S_FLUSH: imem_req_o = 1'b1;
         default: imem_req_o = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         en_q       <= 1'b0;
         fetch_pc_q <= RESET_PC;
         tgt_q      <= RESET_PC;
      end else begin
         en_q <= 1'b1;
         if (state_q == S_FETCH) begin
            if (redirect_i) begin
               if (!imem_req_o || imem_ack_i) fetch_pc_q <= redirect_pc_i;
               else                           tgt_q      <= redirect_pc_i;
            end else if (xfer) begin
               fetch_pc_q <= fetch_pc_q + AW'(INSTR_BYTES);
            end
         end else begin
            if (imem_ack_i)      fetch_pc_q <= redirect_i ? redirect_pc_i : tgt_q;
            else if (redirect_i) tgt_q      <= redirect_pc_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (redirect_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage needs no reset: the head is masked to zero whenever the count is zero.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_pc[wr_ptr_q]    <= fetch_pc_q;
         mem_instr[wr_ptr_q] <= imem_rdata_i;
      end
   end

   assign instr_valid_o = !empty && !redirect_i;
   assign instr_o       = empty ? '0 : mem_instr[rd_ptr_q];
   assign instr_pc_o    = empty ? '0 : mem_pc[rd_ptr_q];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: memory responder plus a {pc, instr} scoreboard.
module tb_fetch_queue;

   logic        clk_sys = 1'b0;
   logic        arst_ni;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;
   logic [31:0] rd_xor;
   logic        valid;
   logic        ready;
   logic [31:0] instr;
   logic [31:0] ipc;

   logic        w_req;
   logic [7:0]  w_addr;
   logic        w_valid;
   logic [7:0]  w_instr;
   logic [7:0]  w_pc;

   logic [63:0] sb [$];
   logic [7:0]  w_pcs [$];
   logic [31:0] m_pc;
   logic [31:0] m_tgt;
   logic        m_en;
   logic        m_flush;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_acc;
   int          cyc_n;
   int          first_valid;

   always #5 clk_sys = ~clk_sys;

   assign rdata = addr ^ rd_xor;

   fetch_queue dut (
      .clk_i         (clk_sys),
      .arst_ni       (arst_ni),
      .redirect_i    (redirect),
      .redirect_pc_i (redirect_pc),
      .imem_req_o    (req),
      .imem_addr_o   (addr),
      .imem_ack_i    (ack),
      .imem_rdata_i  (rdata),
      .instr_valid_o (valid),
      .instr_ready_i (ready),
      .instr_o       (instr),
      .instr_pc_o    (ipc)
   );

   fetch_queue #(.AW(8), .DW(8), .RESET_PC(8'hFE)) dut_wrap (
      .clk_i         (clk_sys),
      .arst_ni       (arst_ni),
      .redirect_i    (1'b0),
      .redirect_pc_i (8'h00),
      .imem_req_o    (w_req),
      .imem_addr_o   (w_addr),
      .imem_ack_i    (1'b1),
      .imem_rdata_i  (w_addr),
      .instr_valid_o (w_valid),
      .instr_ready_i (1'b1),
      .instr_o       (w_instr),
      .instr_pc_o    (w_pc)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: inputs already driven; check, update model, cross the edge.
   task automatic cyc();
      logic        e_req;
      logic        e_valid;
      logic        xfer;
      logic [63:0] head;
      #1;
      e_req = m_flush || (m_en && sb.size() < 4);
      chk("req", req, e_req);
      chk("addr", addr, m_pc);
      e_valid = (sb.size() != 0) && !redirect;
      chk("valid", valid, e_valid);
      if (valid && first_valid < 0) first_valid = cyc_n;
      if (req && ack) n_acc++;
      if (sb.size() == 0) begin
         chk("instr_empty", instr, 0);
         chk("pc_empty", ipc, 0);
      end
      if (e_valid && ready) begin
         head = sb.pop_front();
         chk("head_pc", ipc, head[63:32]);
         chk("head_instr", instr, head[31:0]);
      end
      xfer = e_req && ack;
      if (!m_flush) begin
         if (redirect) begin
            sb.delete();
            if (!e_req || ack) m_pc = redirect_pc;
            else begin
               m_flush = 1'b1;
               m_tgt   = redirect_pc;
            end
         end else if (xfer) begin
            sb.push_back({m_pc, m_pc ^ rd_xor});
            m_pc = m_pc + 32'd2;
         end
      end else begin
         if (redirect) sb.delete();
         if (ack) begin
            m_pc    = redirect ? redirect_pc : m_tgt;
            m_flush = 1'b0;
         end else if (redirect) begin
            m_tgt = redirect_pc;
         end
      end
      if (w_valid && w_pcs.size() < 3) w_pcs.push_back(w_pc);
      cyc_n++;
      @(posedge clk_sys);
      if (arst_ni) m_en = 1'b1;
      #2;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_req"},   req,   0);
      chk({tag, "_addr"},  addr,  0);
      chk({tag, "_valid"}, valid, 0);
      chk({tag, "_instr"}, instr, 0);
      chk({tag, "_pc"},    ipc,   0);
   endtask

   initial begin
      arst_ni     = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      ack         = 1'b0;
      ready       = 1'b0;
      rd_xor      = '0;
      m_pc        = '0;
      m_tgt       = '0;
      m_en        = 1'b0;
      m_flush     = 1'b0;
      n_acc       = 0;
      cyc_n       = 0;
      first_valid = -1;

      #12;
      chk_reset_outputs("reset");
      #10;
      arst_ni = 1'b1;
      ack     = 1'b1;
      ready   = 1'b1;
      repeat (10) cyc();
      chk("first_valid_cycle", first_valid, 2);

      // Fill to full with the consumer stalled.
      redirect = 1'b1; redirect_pc = 32'h0; cyc();
      redirect = 1'b0; ready = 1'b0; n_acc = 0;
      repeat (6) cyc();
      chk("acks_until_full", n_acc, 4);
      chk("req_when_full", req, 0);
      ready = 1'b1; cyc();
      ready = 1'b0; ack = 1'b0;
      #1;
      chk("req_after_pop", req, 1);
      chk("addr_after_pop", addr, 32'h8);
      cyc();

      // Redirect together with an ack while three entries are buffered.
      rd_xor   = 32'h5A5A_0000;
      redirect = 1'b1; redirect_pc = 32'h40; ack = 1'b1; cyc();
      redirect = 1'b0; ack = 1'b0;
      #1;
      chk("redir_addr", addr, 32'h40);
      chk("redir_empty", valid, 0);
      cyc();
      ack = 1'b1; ready = 1'b1; cyc();
      ack = 1'b0;
      #1;
      chk("redir_head_pc", ipc, 32'h40);
      cyc();

      // Stalled request at 0x10, redirected twice before its ack.
      redirect = 1'b1; redirect_pc = 32'h10; ack = 1'b1; cyc();
      ack = 1'b0;
      redirect_pc = 32'h80; cyc();
      redirect_pc = 32'h90; cyc();
      redirect = 1'b0;
      #1;
      chk("stall_addr", addr, 32'h10);
      cyc();
      ack = 1'b1; cyc();
      ack = 1'b0;
      #1;
      chk("after_flush_addr", addr, 32'h90);
      chk("after_flush_req", req, 1);
      cyc();

      // Redirect landing on the same cycle as the flush ack.
      redirect = 1'b1; redirect_pc = 32'hA0; cyc();
      redirect_pc = 32'hB0; ack = 1'b1; cyc();
      redirect = 1'b0; ack = 1'b0;
      #1;
      chk("flush_ack_redir_addr", addr, 32'hB0);
      cyc();
      ack = 1'b1; ready = 1'b1;
      repeat (4) cyc();

      // Async reset with two entries buffered and a request pending.
      ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h20; cyc();
      redirect = 1'b0;
      repeat (2) cyc();
      ack = 1'b0; cyc();
      #1;
      chk("pre_reset_req", req, 1);
      arst_ni = 1'b0;
      #1;
      chk_reset_outputs("async_reset");
      sb.delete();
      m_pc    = '0;
      m_en    = 1'b0;
      m_flush = 1'b0;
      arst_ni = 1'b1;
      ack = 1'b1; ready = 1'b1; rd_xor = '0;
      repeat (6) cyc();

      chk("wrap_count", w_pcs.size(), 3);
      if (w_pcs.size() >= 3) begin
         chk("wrap_pc0", w_pcs[0], 8'hFE);
         chk("wrap_pc1", w_pcs[1], 8'h00);
         chk("wrap_pc2", w_pcs[2], 8'h02);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
